// File: rtl/mby_egr_sch_pkg.sv
// mby_egr_sch_pkg: shared types for the egress-scheduler winner sink.
// Revision: 1.0
`default_nettype none

package mby_egr_sch_pkg;

    localparam int EGR_SCH_WIDTH    = 16;
    localparam int EGR_SCH_MAX_COST = 160;
    localparam int EGR_SCH_PAYLOAD  = 16;
    localparam int EGR_SCH_PW       = $clog2(EGR_SCH_WIDTH);
    localparam int EGR_SCH_CW       = $clog2(EGR_SCH_MAX_COST);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } egr_sch_win_sink_state_e;

    typedef struct packed {
        logic [EGR_SCH_PW-1:0]      port;
        logic [EGR_SCH_CW-1:0]      cost;
        logic [EGR_SCH_PAYLOAD-1:0] payload;
    } egr_sch_win_entry_t;

endpackage

`default_nettype wire

// File: rtl/mby_egr_sch_win_fifo.sv
// mby_egr_sch_win_fifo: DEPTH-entry flop FIFO holding accepted grants; no pass-through.
// Revision: 1.0
`default_nettype none

module mby_egr_sch_win_fifo #(
    parameter int  DW    = 8,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] rd_data_o,
    output logic [AW:0]   count_o,
    output logic          empty_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full;
    assign pop_ok  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

`default_nettype wire

// File: rtl/mby_egr_sch_win_sink.sv
// mby_egr_sch_win_sink: credit- and space-gated consumer of the scheduler winner.
// Optional checker build macro: MBY_EGR_SCH_WIN_SINK_CHK_EN. Revision: 1.0
`default_nettype none

module mby_egr_sch_win_sink
    import mby_egr_sch_pkg::*;
#(
    parameter int  WIDTH      = 16,
    parameter int  MAX_COST   = 160,
    parameter int  PAYLOAD    = 16,
    parameter int  DEPTH      = 4,
    parameter int  CREDIT_MAX = 1023,
    localparam int CW         = $clog2(MAX_COST),
    localparam int PW         = $clog2(WIDTH),
    localparam int CRW        = $clog2(CREDIT_MAX + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   win,
    input  logic [CW-1:0]      win_cost,
    input  logic [PAYLOAD-1:0] win_payload,
    output logic               pop,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PW-1:0]      out_port,
    output logic [CW-1:0]      out_cost,
    output logic [PAYLOAD-1:0] out_payload,
    input  logic               credit_return,
    input  logic [CRW-1:0]     credit_return_amt,
    output logic [CRW-1:0]     credit_avail,
    input  logic [CRW-1:0]     cfg_credit_init,
    input  logic               cfg_hold,
    output logic               err_onehot,
    output logic               err_credit_ovf
);

    localparam int CNTW = $clog2(DEPTH) + 1;
    localparam int DW   = PW + CW + PAYLOAD;

    egr_sch_win_sink_state_e state_q, state_d;
    logic [CRW-1:0]  credit_q, credit_d;
    logic [CRW:0]    cost_ext;
    logic [CRW:0]    credit_sum;
    logic            credit_sat;
    logic            credit_ok;
    logic [PW-1:0]   port_enc;
    logic [CNTW-1:0] fifo_count;
    logic            fifo_empty;
    logic [DW-1:0]   fifo_rd_data;

    // Scanning from the top down leaves the lowest set index.
    always_comb begin
        port_enc = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (win[i]) begin
                port_enc = PW'(i);
            end
        end
    end

    assign cost_ext  = (CRW+1)'(win_cost);
    assign credit_ok = ({1'b0, credit_q} >= cost_ext);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_INIT: state_d = ST_RUN;
            ST_RUN: begin
                if (cfg_hold) begin
                    state_d = ST_HOLD;
                end
                pop = (|win) && (fifo_count < CNTW'(DEPTH)) && credit_ok;
            end
            ST_HOLD: begin
                if (!cfg_hold) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // One spare bit keeps the return-plus-balance sum from wrapping before saturation.
    assign credit_sum = {1'b0, credit_q}
                      + (credit_return ? {1'b0, credit_return_amt} : '0)
                      - (pop ? cost_ext : '0);
    assign credit_sat = (credit_sum > (CRW+1)'(CREDIT_MAX));

    always_comb begin
        credit_d = credit_sum[CRW-1:0];
        if (state_q == ST_INIT) begin
            credit_d = cfg_credit_init;
        end else if (credit_sat) begin
            credit_d = CRW'(CREDIT_MAX);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign credit_avail = credit_q;

    mby_egr_sch_win_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (pop),
        .push_data_i ({port_enc, win_cost, win_payload}),
        .pop_i       (out_valid && out_ready),
        .rd_data_o   (fifo_rd_data),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign {out_port, out_cost, out_payload} = fifo_rd_data;

`ifdef MBY_EGR_SCH_WIN_SINK_CHK_EN
    logic err_onehot_q;
    logic err_ovf_q;
    logic multi_hot;

    assign multi_hot = |(win & (win - WIDTH'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_onehot_q <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            if (multi_hot) begin
                err_onehot_q <= 1'b1;
            end
            if ((state_q != ST_INIT) && credit_sat) begin
                err_ovf_q <= 1'b1;
            end
        end
    end

    assign err_onehot     = err_onehot_q;
    assign err_credit_ovf = err_ovf_q;
`else
    assign err_onehot     = 1'b0;
    assign err_credit_ovf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/mby_egr_sch_win_sink.md
# mby_egr_sch_win_sink

Consumer end of the egress-scheduler arbiter handshake. Accepts the registered winner (`win`/`win_cost`/`win_payload`) from a scheduler arbiter and returns `pop`. Gates acceptance on two conditions: a downstream cost-credit budget and space in a small output FIFO. Presents accepted grants downstream as binary port, cost and payload under a valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, 16, number of arbiter requesters (one-hot `win` width)
- `MAX_COST`, 160, cost range; cost width `CW = $clog2(MAX_COST)`
- `PAYLOAD`, 16, payload width
- `DEPTH`, 4, output FIFO entries (power of two, ≥2)
- `CREDIT_MAX`, 1023, credit counter ceiling; width `CRW = $clog2(CREDIT_MAX+1)`

Ports:
- `clk` in 1: single clock
- `reset` in 1: asynchronous, active-high
- `win` in WIDTH: one-hot winner from arbiter, flopped upstream
- `win_cost` in CW: cost of winner
- `win_payload` in PAYLOAD: payload of winner
- `pop` out 1: accepts current winner this cycle
- `out_valid` out 1: FIFO head valid
- `out_ready` in 1: downstream accepts head
- `out_port` out $clog2(WIDTH): binary index of head's requester
- `out_cost` out CW: head cost
- `out_payload` out PAYLOAD: head payload
- `credit_return` in 1: downstream returns credits this cycle
- `credit_return_amt` in CRW: amount returned
- `credit_avail` out CRW: current credit count
- `cfg_credit_init` in CRW: credits loaded after reset; quasi-static
- `cfg_hold` in 1: stop popping; FIFO keeps draining
- `err_onehot` out 1: sticky, `win` had >1 bit set
- `err_credit_ovf` out 1: sticky, credit sum exceeded CREDIT_MAX

## Operation
- States: INIT, RUN, HOLD. Reset enters INIT.
- INIT: load `credit_avail <= cfg_credit_init`, then go to RUN. INIT lasts exactly one cycle.
- RUN: if `cfg_hold`, go to HOLD. HOLD: if `!cfg_hold`, go to RUN. `pop` is never asserted in INIT or HOLD.
- `pop = (state==RUN) && |win && (count < DEPTH) && (credit_avail >= win_cost)`.
  - All terms come from flops plus one compare. No combinational path from `out_ready` or `credit_return`.
- On `pop`: push {port, cost, payload} into the FIFO.
  - `port` is the lowest set index of `win`.
  - A cost of 0 is legal and always passes the credit check.
- Credit update: `next = credit_avail + (credit_return ? credit_return_amt : 0) - (pop ? win_cost : 0)`.
  - Compute at CRW+1 bits.
  - If `next > CREDIT_MAX`: saturate to CREDIT_MAX and set `err_credit_ovf`.
- FIFO full blocks `pop` even when the head drains in the same cycle (no pass-through).
- FIFO head pops when `out_valid && out_ready`. Simultaneous push and pop leaves `count` unchanged.
- Read/write pointers wrap modulo DEPTH. `count` is $clog2(DEPTH)+1 bits.
- Sticky errors clear only on reset.

## Timing
- Reset values:
  - `pop` 0, `out_valid` 0, `out_port`/`out_cost`/`out_payload` 0
  - `credit_avail` 0, errors 0, FIFO empty
- `pop` asserted in cycle t:
  - entry visible on `out_valid`/`out_*` at t+1 (FIFO was empty)
  - `credit_avail` reduced at t+1
- `credit_return` in cycle t: reflected in `credit_avail` at t+1 and usable for `pop` at t+1.
- A FIFO slot freed by `out_ready` at t allows `pop` at t+1.
- Sustained throughput: 1 grant/cycle while the FIFO drains every cycle and credits suffice.
- Reset mid-operation: FIFO contents discarded and credits cleared immediately. INIT follows reset deassertion.

## Configuration
- `MBY_EGR_SCH_WIN_SINK_CHK_EN` defined:
  - one-hot checker on `win` when `|win`
  - credit overflow detection drives `err_onehot` and `err_credit_ovf`
- Undefined:
  - both error outputs tied 0
  - overflow still saturates silently
  - checker logic absent

## Structure
- `mby_egr_sch_pkg` holds:
  - `egr_sch_win_sink_state_e` enum (INIT/RUN/HOLD)
  - `egr_sch_win_entry_t` struct (port, cost, payload), parameterized by package constants
- Sub-module `mby_egr_sch_win_fifo`: DEPTH-entry flop FIFO with push, pop, count, full, empty. Instantiated once.
- The one-hot-to-binary encoder and credit logic stay in the top level.

## Test plan
- Reset with `cfg_credit_init`=100 → `credit_avail`=0 during reset, 100 one cycle after deassertion; `pop`=0 in the INIT cycle.
- Credits 100, `win`=16'h0004, cost 40, payload 16'hABCD, `out_ready`=1 → `pop`=1; next cycle `out_valid`=1, `out_port`=2, `out_cost`=40, `out_payload`=16'hABCD, `credit_avail`=60.
- Credits 30, winner cost 40 → `pop`=0. `credit_return_amt`=10 for one cycle → `credit_avail`=40 and `pop`=1 next cycle, then `credit_avail`=0.
- `out_ready`=0, five back-to-back cost-1 winners → four pops, fifth held with count=4. `out_ready`=1 for one cycle → `pop`=1 the following cycle.
- Credits 100, `pop` of cost 40 with simultaneous return of 25 → `credit_avail`=85. Credits 1000 plus return of 100 → saturates at 1023, `err_credit_ovf`=1 (CHK_EN).
- `win`=16'h0011 with CHK_EN → `err_onehot`=1 sticky, `out_port`=0. Asserting `cfg_hold` → `pop`=0 from the next cycle while the FIFO still drains.
